i2c_master_nbyte: RTL and testbench
===================================

// Module: i2c_master_nbyte
// PURPOSE
//  Parametrised I2C master, successor to the fixed single-byte master.
//  Executes START, 7-bit address + R/W, 0..2^LEN_W-1 data bytes, STOP. Multi-byte burst, slave-NACK
//  detection, SCL clock stretching, open-drain drive outputs.
//  Sits between a host command interface and the board SCL/SDA pads (external tristate).
// PARAMETERS
//  QTR    4  clk cycles per SCL quarter-bit phase (SCL period = 4*QTR clk); legal >= 2
//  LEN_W  4  width of n_byte; max burst = 2^LEN_W-1 bytes
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      1-cycle request; sampled only when busy=0
//  rw        in   1      0=write, 1=read; captured with start
//  address   in   7      slave address; captured with start
//  n_byte    in   LEN_W  data byte count; captured with start; 0 = address probe only
//  wr_data   in   8      write byte; sampled in the cycle wr_load=1
//  wr_load   out  1      1-cycle pulse: wr_data captured into shifter
//  rd_data   out  8      received byte, held until next rd_valid
//  rd_valid  out  1      1-cycle pulse: rd_data updated
//  busy      out  1      1 from cycle after accepted start until done
//  done      out  1      1-cycle pulse after STOP completes
//  ack_err   out  1      set on slave NACK; held until next accepted start
//  scl_in    in   1      pad SCL level (stretch sensing)
//  scl_oe    out  1      1 = pull SCL low, 0 = release
//  sda_in    in   1      pad SDA level
//  sda_oe    out  1      1 = pull SDA low, 0 = release
// BEHAVIOUR
//  Reset: all outputs 0 (lines released), FSM=IDLE, counters/shifters 0; async, valid mid-transfer.
//  Bit timing: 4 phases of QTR clk: P0,P1 SCL low (SDA changes at P0 entry); P2,P3 SCL released;
//   sda_in sampled at last cycle of P2. Stretch: in P2/P3, if scl_oe=0 and scl_in=0, phase counter holds.
//  FSM: IDLE -> START -> ADDR(8 bits: address,rw) -> AACK -> {WRITE|READ} -> {WACK|MACK} ... -> STOP -> IDLE.
//  START: SDA released 2 phases with SCL high, then sda_oe=1 for 2 phases, then SCL low.
//  AACK/WACK: master releases SDA; sampled 1 = NACK -> ack_err=1, go STOP (remaining bytes skipped).
//  AACK ok: n_byte=0 -> STOP; rw=0 -> WRITE; rw=1 -> READ.
//  WRITE: wr_load pulses on entry (1st clk); MSB first. WACK ok: bytes left -> WRITE else STOP.
//  READ: MSB first; at end of byte rd_data<=shifter, rd_valid pulse; MACK drives ACK (sda_oe=1)
//   if bytes remain, NACK (sda_oe=0) on last byte; then READ or STOP.
//  STOP: SCL low with sda_oe=1 (1 phase), release SCL (1 phase), release SDA (2 phases); then done=1
//   for 1 cycle, busy=0 same cycle, FSM=IDLE.
//  start while busy=1 ignored; start in the same cycle as done is ignored.
//  Byte counter: LEN_W bits, loaded with n_byte, decremented per completed byte; no wrap.
//  ack_err cleared on accepted start; done still pulses on NACK-terminated transfers.
//  Outputs registered; sda_oe/scl_oe never both changing in same cycle except reset.
// TESTING
//  Write 0x50, n_byte=2, wr_data A5 then 3C, model ACKs -> SDA frames A0,A5,3C; 2 wr_load; done; ack_err=0.
//  Read 0x51, n_byte=3, model returns 11,22,33 -> 3 rd_valid with those values; ACK,ACK,NACK; STOP.
//  Address NACK on 0x7F write, n_byte=4 -> ack_err=1, no wr_load after first, STOP, done.
//  Model holds SCL low 37 clk in bit 3 of a write -> bit period extended by 37, data intact.
//  rst_n low mid data byte -> scl_oe=sda_oe=busy=0 immediately; next start runs clean transfer.
//  start pulsed while busy, and n_byte=0 probe -> ignored / address-only frame, done, no data phases.

Source files
------------

// File: rtl/i2c_master_nbyte.sv
// rtl/i2c_master_nbyte.sv - multi-byte I2C master with NACK detection and clock stretching
//
// Runs START, 7-bit address + R/W, 0..2^LEN_W-1 data bytes, then STOP.
// The bus is driven open-drain through scl_oe/sda_oe, and the pads are read back through scl_in/sda_in.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, rw, address, n_byte  command, captured when start=1 while idle
//   wr_data, wr_load            write byte; wr_data is sampled in the cycle wr_load=1
//   rd_data, rd_valid           received byte and its 1-cycle strobe
//   busy, done, ack_err         status: in transfer, end-of-transfer pulse, slave NACK seen
//   scl_in, scl_oe              SCL pad level; 1 = pull SCL low
//   sda_in, sda_oe              SDA pad level; 1 = pull SDA low
module i2c_master_nbyte #(
  parameter int QTR   = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       address,
  input  logic [LEN_W-1:0] n_byte,
  input  logic [7:0]       wr_data,
  output logic             wr_load,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  input  logic             scl_in,
  output logic             scl_oe,
  input  logic             sda_in,
  output logic             sda_oe
);

  localparam int QW = (QTR > 2) ? $clog2(QTR) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_MACK, S_STOP
  } state_t;

  state_t           state;
  logic [QW-1:0]    qcnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       shifter;
  logic [LEN_W-1:0] byte_cnt;
  logic             rw_q;
  logic             ack_bit;

  logic stall, q_last, tick, bit_end;
  logic scl_tgt, sda_tgt;

  // The phase counter freezes while SCL is released but held low by a slave.
  always_comb begin
    stall   = phase[1] && !scl_oe && !scl_in;
    q_last  = (qcnt == QW'(QTR - 1));
    tick    = (state != S_IDLE) && !stall && q_last;
    bit_end = tick && (phase == 2'd3);
  end

  // Line levels wanted for the current state and phase.
  always_comb begin
    scl_tgt = 1'b0;
    sda_tgt = 1'b0;
    case (state)
      S_START: sda_tgt = phase[1];
      S_ADDR, S_WRITE: begin
        scl_tgt = !phase[1];
        sda_tgt = !shifter[7];
      end
      S_AACK, S_WACK, S_READ: scl_tgt = !phase[1];
      S_MACK: begin
        scl_tgt = !phase[1];
        sda_tgt = (byte_cnt != '0);
      end
      S_STOP: begin
        scl_tgt = (phase == 2'd0);
        sda_tgt = !phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      byte_cnt <= '0;
      rw_q     <= 1'b0;
      ack_bit  <= 1'b0;
      wr_load  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      wr_load  <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (state == S_IDLE) begin
        scl_oe <= 1'b0;
        sda_oe <= 1'b0;
        // The cycle carrying done is still IDLE; a start there is dropped.
        if (start && !done) begin
          state    <= S_START;
          busy     <= 1'b1;
          ack_err  <= 1'b0;
          shifter  <= {address, rw};
          rw_q     <= rw;
          byte_cnt <= n_byte;
          qcnt     <= '0;
          phase    <= '0;
          bit_cnt  <= '0;
        end
      end else begin
        scl_oe <= scl_tgt;
        // SDA moves one cycle after SCL has been pulled low, so the two lines never switch together.
        if (!(phase == 2'd0 && qcnt == '0)) sda_oe <= sda_tgt;
        if (state == S_WRITE && wr_load) shifter <= wr_data;
        if (!stall) begin
          if (q_last) begin
            qcnt  <= '0;
            phase <= phase + 2'd1;
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        if (tick && phase == 2'd2) begin
          ack_bit <= sda_in;
          if (state == S_READ) shifter <= {shifter[6:0], sda_in};
        end
        if (bit_end) begin
          case (state)
            S_START: begin
              state   <= S_ADDR;
              bit_cnt <= '0;
            end
            S_ADDR, S_WRITE: begin
              if (bit_cnt == 3'd7) begin
                state <= (state == S_ADDR) ? S_AACK : S_WACK;
                if (state == S_WRITE && byte_cnt != '0) byte_cnt <= byte_cnt - LEN_W'(1);
              end else begin
                shifter <= {shifter[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            S_AACK, S_WACK: begin
              bit_cnt <= '0;
              if (ack_bit) begin
                ack_err <= 1'b1;
                state   <= S_STOP;
              end else if (byte_cnt == '0) begin
                state <= S_STOP;
              end else if (state == S_AACK && rw_q) begin
                state <= S_READ;
              end else begin
                state   <= S_WRITE;
                wr_load <= 1'b1;
              end
            end
            S_READ: begin
              if (bit_cnt == 3'd7) begin
                rd_data  <= shifter;
                rd_valid <= 1'b1;
                state    <= S_MACK;
                if (byte_cnt != '0) byte_cnt <= byte_cnt - LEN_W'(1);
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            S_MACK: begin
              bit_cnt <= '0;
              state   <= (byte_cnt != '0) ? S_READ : S_STOP;
            end
            S_STOP: begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// tb/tb_i2c_master_nbyte.sv - self-checking bench for i2c_master_nbyte with a bus-level slave
module tb_i2c_master_nbyte;

  localparam int QTR     = 4;
  localparam int STRETCH = 37;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] address = '0;
  logic [3:0] n_byte = '0;
  logic [7:0] wr_data = '0;
  logic       wr_load, rd_valid, busy, done, ack_err, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic       scl_pad, sda_pad;

  bit         hold_scl = 1'b0;
  bit         slave_sda_low = 1'b0;

  assign scl_pad = !(scl_oe || hold_scl);
  assign sda_pad = !(sda_oe || slave_sda_low);

  i2c_master_nbyte #(.QTR(QTR), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .address(address),
    .n_byte(n_byte), .wr_data(wr_data), .wr_load(wr_load), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .ack_err(ack_err),
    .scl_in(scl_pad), .scl_oe(scl_oe), .sda_in(sda_pad), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model: sees only the pad levels ----------------
  bit [63:0]  s_data = '0;
  bit         slave_nack = 1'b0;
  bit         stretch_en = 1'b0;
  int         cyc = 0, bcnt = 0, byte_idx = 0, hcnt = 0, stops = 0;
  bit         go = 1'b0, is_read = 1'b0, scl_prev = 1'b1, sda_prev = 1'b1;
  logic [7:0] rx = '0, tx = '0;
  logic [7:0] frame_q[$];
  bit         ack_q[$];
  int         rise_q[$];

  always @(negedge clk) begin : slave
    bit sn, dn;
    cyc++;
    if (!rst_n) begin
      hold_scl = 1'b0; slave_sda_low = 1'b0; bcnt = 0; byte_idx = 0;
      go = 1'b0; is_read = 1'b0; scl_prev = 1'b1; sda_prev = 1'b1;
    end else begin
      if (hold_scl && !scl_oe) begin
        if (hcnt == STRETCH) hold_scl = 1'b0;
        else hcnt++;
      end
      sn = !(scl_oe || hold_scl);
      dn = !(sda_oe || slave_sda_low);
      if (scl_prev && sn && sda_prev && !dn) begin
        bcnt = 0; byte_idx = 0; go = 1'b0; is_read = 1'b0;
      end else if (scl_prev && sn && !sda_prev && dn) begin
        stops++;
      end else if (!scl_prev && sn) begin
        rise_q.push_back(cyc);
        if (bcnt < 8) rx = {rx[6:0], dn};
        else ack_q.push_back(dn);
        bcnt++;
      end else if (scl_prev && !sn) begin
        if (bcnt == 8) begin
          frame_q.push_back(rx);
          if (byte_idx == 0) begin
            is_read = rx[0];
            go = !slave_nack;
            slave_sda_low = !slave_nack;
          end else begin
            slave_sda_low = !is_read;
          end
        end else if (bcnt == 9) begin
          bcnt = 0;
          byte_idx++;
          slave_sda_low = 1'b0;
          if (is_read && go && (byte_idx == 1 || ack_q[$] == 1'b0)) begin
            tx = s_data[63-8*(byte_idx-1) -: 8];
            slave_sda_low = !tx[7];
          end else begin
            go = 1'b0;
          end
        end else if (is_read && go && byte_idx >= 1 && bcnt >= 1) begin
          slave_sda_low = !tx[7-bcnt];
        end
        if (stretch_en && !is_read && byte_idx == 1 && bcnt == 3) begin
          hold_scl = 1'b1;
          hcnt = 0;
        end
      end
      scl_prev = sn;
      sda_prev = dn;
    end
  end

  // ---------------- transactions ----------------
  typedef struct {
    bit        rw;
    bit [6:0]  addr;
    int        n;
    bit [63:0] data;
    bit        nack;
    bit        stretch;
    bit        poke;
    bit        exp_err;
    int        exp_wl;
    int        exp_rv;
  } txn_t;

  task automatic run_txn(input txn_t t, input string nm);
    logic [7:0] exp_b[$];
    bit         exp_a[$];
    logic [7:0] rd_got[$];
    int         f0, a0, r0, s0, wl, widx;
    bit         seen_done;
    // Expected bus frames: address byte, then data bytes unless the address was refused.
    exp_b.push_back({t.addr, t.rw});
    exp_a.push_back(t.nack);
    if (!t.nack) begin
      for (int i = 0; i < t.n; i++) begin
        exp_b.push_back(t.data[63-8*i -: 8]);
        exp_a.push_back(t.rw ? (i == t.n - 1) : 1'b0);
      end
    end
    f0 = frame_q.size(); a0 = ack_q.size(); r0 = rise_q.size(); s0 = stops;
    s_data = t.data; slave_nack = t.nack; stretch_en = t.stretch;
    wl = 0; widx = 0; seen_done = 1'b0;

    @(negedge clk);
    start = 1'b1; rw = t.rw; address = t.addr; n_byte = 4'(t.n);
    @(negedge clk);
    start = 1'b0;
    check({nm, " busy_after_start"}, busy, 1);
    for (int c = 0; c < 6000 && !seen_done; c++) begin
      @(negedge clk);
      if (wr_load) begin
        wl++;
        if (widx < 8) wr_data = t.data[63-8*widx -: 8];
        widx++;
      end
      if (rd_valid) rd_got.push_back(rd_data);
      if (t.poke && c == 40) begin
        start = 1'b1; address = ~t.addr; rw = ~t.rw; n_byte = 4'hF;
      end
      if (t.poke && c == 41) begin
        start = 1'b0; address = t.addr; rw = t.rw; n_byte = 4'(t.n);
      end
      if (done) begin
        seen_done = 1'b1;
        check({nm, " busy_at_done"}, busy, 0);
        start = 1'b1;
      end
    end
    check({nm, " done_seen"}, seen_done, 1);
    if (!seen_done) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({nm, " start_with_done_ignored"}, busy, 0);
    repeat (3) @(negedge clk);
    check({nm, " ack_err"}, ack_err, t.exp_err);
    check({nm, " wr_load_count"}, wl, t.exp_wl);
    check({nm, " rd_valid_count"}, rd_got.size(), t.exp_rv);
    for (int i = 0; i < rd_got.size() && i < t.exp_rv; i++)
      check($sformatf("%s rd_data%0d", nm, i), rd_got[i], t.data[63-8*i -: 8]);
    check({nm, " frame_count"}, frame_q.size() - f0, exp_b.size());
    for (int i = 0; i < exp_b.size() && f0 + i < frame_q.size(); i++) begin
      check($sformatf("%s frame%0d", nm, i), frame_q[f0+i], exp_b[i]);
      if (a0 + i < ack_q.size())
        check($sformatf("%s ackbit%0d", nm, i), ack_q[a0+i], exp_a[i]);
    end
    check({nm, " stop_count"}, stops - s0, 1);
    if (t.stretch) begin
      if (rise_q.size() > r0 + 13) begin
        check({nm, " period_bit2"}, rise_q[r0+11] - rise_q[r0+10], 4*QTR);
        check({nm, " period_bit3"}, rise_q[r0+12] - rise_q[r0+11], 4*QTR + STRETCH);
        check({nm, " period_bit4"}, rise_q[r0+13] - rise_q[r0+12], 4*QTR);
      end else begin
        check({nm, " rise_count"}, rise_q.size() - r0, 14);
      end
    end
  endtask

  txn_t tbl[8];

  initial begin
    // rw, addr, n, data, nack, stretch, poke, exp_err, exp_wl, exp_rv
    tbl[0] = '{1'b0, 7'h50, 2, 64'hA53C_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
    tbl[1] = '{1'b1, 7'h51, 3, 64'h1122_3300_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3};
    tbl[2] = '{1'b0, 7'h7F, 4, 64'hDEAD_BEEF_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[3] = '{1'b0, 7'h2A, 2, 64'h5AC3_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    tbl[4] = '{1'b0, 7'h33, 0, 64'h0,                   1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{1'b1, 7'h0F, 1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
    tbl[6] = '{1'b1, 7'h44, 2, 64'h7E81_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[7] = '{1'b0, 7'h01, 7, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, 1'b0, 7, 0};

    repeat (3) @(negedge clk);
    check("reset scl_oe", scl_oe, 0);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pulses", {wr_load, rd_valid, ack_err}, 0);
    check("reset rd_data", rd_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Asynchronous reset in the middle of the first data byte.
    @(negedge clk);
    start = 1'b1; rw = 1'b0; address = 7'h50; n_byte = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (wr_load) wr_data = 8'hA5;
    end
    check("midreset busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreset scl_oe", scl_oe, 0);
    check("midreset sda_oe", sda_oe, 0);
    check("midreset busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_txn(tbl[0], "after_reset");

    for (int k = 0; k < 8; k++) begin
      txn_t r;
      r.n       = $urandom_range(0, 5);
      r.rw      = (r.n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      r.addr    = 7'($urandom);
      r.data    = {$urandom, $urandom};
      r.nack    = ($urandom_range(0, 3) == 0);
      r.stretch = 1'b0;
      r.poke    = 1'($urandom_range(0, 1));
      r.exp_err = r.nack;
      r.exp_wl  = (!r.nack && !r.rw) ? r.n : 0;
      r.exp_rv  = (!r.nack && r.rw) ? r.n : 0;
      run_txn(r, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
